// File: rtl/nv_nvdla_mcif_wr_pkg.sv
// Shared definitions for the MCIF write path: CQ payload layout, AXI response
// codes and a constant-foldable clog2.
package nv_nvdla_mcif_wr_pkg;

    localparam int ACK_BIT = 0;
    localparam int LEN_LSB = 1;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/nv_nvdla_mcif_write_eg_skid.sv
// Two-entry valid/ready skid buffer with a registered ready, so the upstream
// ready never depends combinationally on the downstream pop.
module nv_nvdla_mcif_write_eg_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_pd,
    output logic         out_vld,
    input  logic         out_pop,
    output logic [W-1:0] out_pd
);

    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic         rdy_q;
    logic         push;
    logic         pop;

    assign push    = in_vld & rdy_q;
    assign pop     = out_pop & (cnt_q != 2'd0);
    assign in_rdy  = rdy_q;
    assign out_vld = (cnt_q != 2'd0);
    assign out_pd  = ent0_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state uses <= so all flops sample pre-edge values; blocking assignments would race.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            // NOTE: the entries are reset too, so a freshly reset head never carries X.
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= ~cnt_d[1];
            if (pop) begin
                // Ready is low when full, so push+pop only happens with one entry held.
                ent0_q <= (push && cnt_q == 2'd1) ? in_pd : ent1_q;
            end else if (push) begin
                if (cnt_q == 2'd0) ent0_q <= in_pd;
                else               ent1_q <= in_pd;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_mcif_write_eg_mc.sv
// Write-response egress: matches AXI B beats by ID to per-channel completion
// queues, returns burst length for credit release and pulses completion/error.
module nv_nvdla_mcif_write_eg_mc
    import nv_nvdla_mcif_wr_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ID_W    = 8,
    parameter int LEN_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rst,
    input  logic                          noc2mcif_axi_b_bvalid,
    output logic                          noc2mcif_axi_b_bready,
    input  logic [ID_W-1:0]               noc2mcif_axi_b_bid,
    input  logic [1:0]                    noc2mcif_axi_b_bresp,
    input  logic [NUM_CH-1:0]             cq_rd_pvld,
    output logic [NUM_CH-1:0]             cq_rd_prdy,
    input  logic [NUM_CH*(LEN_W+1)-1:0]   cq_rd_pd,
    output logic                          eg2ig_axi_vld,
    output logic [LEN_W-1:0]              eg2ig_axi_len,
    output logic [NUM_CH-1:0]             mcif2client_wr_rsp_complete,
    output logic [NUM_CH-1:0]             mcif2client_wr_rsp_err,
    output logic                          orphan_err,
    output logic [7:0]                    rsp_err_cnt
);

    localparam int          CH_W    = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1;
    localparam int          PD_W    = LEN_W + 1;
    localparam int          SKID_W  = CH_W + 3;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic              bid_hi_nz;
    logic              head_vld;
    logic [SKID_W-1:0] head_pd;
    logic [CH_W-1:0]   head_ch;
    logic              head_hi;
    axi_resp_e         head_resp;
    logic              head_pop;

    logic              sel_hit;
    logic              sel_pvld;
    logic [LEN_W-1:0]  sel_len;
    logic              sel_ack;
    logic [NUM_CH-1:0] ch_hot;

    logic              live;
    logic              in_range;
    logic              match;
    logic              stall;
    logic              oor_drop;
    logic              to_drop;
    logic [15:0]       stall_cnt_q;

    // Upper ID bits are only kept as a single "nonzero" flag for range checking.
    if (ID_W > CH_W) begin : g_hi
        assign bid_hi_nz = |noc2mcif_axi_b_bid[ID_W-1:CH_W];
    end else begin : g_nohi
        assign bid_hi_nz = 1'b0;
    end

    nv_nvdla_mcif_write_eg_skid #(.W(SKID_W)) u_skid (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .in_vld  (noc2mcif_axi_b_bvalid),
        .in_rdy  (noc2mcif_axi_b_bready),
        .in_pd   ({noc2mcif_axi_b_bid[CH_W-1:0], bid_hi_nz, noc2mcif_axi_b_bresp}),
        .out_vld (head_vld),
        .out_pop (head_pop),
        .out_pd  (head_pd)
    );

    assign head_ch   = head_pd[SKID_W-1 -: CH_W];
    assign head_hi   = head_pd[2];
    assign head_resp = axi_resp_e'(head_pd[1:0]);

    // Channel mux over existing channels only; sel_hit low means c >= NUM_CH.
    always_comb begin
        sel_hit  = 1'b0;
        sel_pvld = 1'b0;
        sel_len  = '0;
        sel_ack  = 1'b0;
        ch_hot   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (head_ch == CH_W'(i)) begin
                sel_hit   = 1'b1;
                sel_pvld  = cq_rd_pvld[i];
                sel_len   = cq_rd_pd[i*PD_W+LEN_LSB +: LEN_W];
                sel_ack   = cq_rd_pd[i*PD_W+ACK_BIT];
                ch_hot[i] = 1'b1;
            end
        end
    end

    // Reset gates the match stage so a reset cycle never pops a CQ.
    assign live     = head_vld & ~nvdla_core_rst;
    assign in_range = ~head_hi & sel_hit;
    assign match    = live & in_range & sel_pvld;
    assign stall    = live & in_range & ~sel_pvld;
    assign oor_drop = live & ~in_range;
    assign to_drop  = stall & (stall_cnt_q == TO_LAST);
    assign head_pop = match | oor_drop | to_drop;

    assign cq_rd_prdy    = match ? ch_hot : '0;
    assign eg2ig_axi_vld = match;
    assign eg2ig_axi_len = match ? sel_len : '0;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_cnt_q                 <= '0;
            mcif2client_wr_rsp_complete <= '0;
            mcif2client_wr_rsp_err      <= '0;
            orphan_err                  <= 1'b0;
            rsp_err_cnt                 <= '0;
        end else begin
            if (head_pop)   stall_cnt_q <= '0;
            else if (stall) stall_cnt_q <= stall_cnt_q + 16'd1;

            mcif2client_wr_rsp_complete <= (match && sel_ack) ? ch_hot : '0;
            mcif2client_wr_rsp_err      <= (match && head_resp != OKAY) ? ch_hot : '0;
            orphan_err                  <= orphan_err | oor_drop | to_drop;

            if (match && head_resp != OKAY && rsp_err_cnt != 8'hff) begin
                rsp_err_cnt <= rsp_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_mc.sv
// Scoreboard bench for the MCIF write-response egress: expected credit returns
// are queued as beats are driven and retired as eg2ig pulses appear.
module tb_nv_nvdla_mcif_write_eg_mc;

    localparam int NUM_CH = 5;
    localparam int ID_W   = 8;
    localparam int LEN_W  = 2;
    localparam int PD_W   = LEN_W + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     bvalid;
    logic [ID_W-1:0]          bid;
    logic [1:0]               bresp;
    logic [NUM_CH-1:0]        pvld;
    logic [NUM_CH*PD_W-1:0]   pd;

    logic                     bready;
    logic [NUM_CH-1:0]        prdy;
    logic                     eg_vld;
    logic [LEN_W-1:0]         eg_len;
    logic [NUM_CH-1:0]        cmp;
    logic [NUM_CH-1:0]        err;
    logic                     orphan;
    logic [7:0]               ecnt;

    logic                     t_bready;
    logic [NUM_CH-1:0]        t_prdy;
    logic                     t_eg_vld;
    logic [LEN_W-1:0]         t_eg_len;
    logic [NUM_CH-1:0]        t_cmp;
    logic [NUM_CH-1:0]        t_err;
    logic                     t_orphan;
    logic [7:0]               t_ecnt;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_eg_mc #(.NUM_CH(NUM_CH), .ID_W(ID_W), .LEN_W(LEN_W), .TIMEOUT(255)) dut (
        .nvdla_core_clk              (clk),
        .nvdla_core_rst              (rst),
        .noc2mcif_axi_b_bvalid       (bvalid),
        .noc2mcif_axi_b_bready       (bready),
        .noc2mcif_axi_b_bid          (bid),
        .noc2mcif_axi_b_bresp        (bresp),
        .cq_rd_pvld                  (pvld),
        .cq_rd_prdy                  (prdy),
        .cq_rd_pd                    (pd),
        .eg2ig_axi_vld               (eg_vld),
        .eg2ig_axi_len               (eg_len),
        .mcif2client_wr_rsp_complete (cmp),
        .mcif2client_wr_rsp_err      (err),
        .orphan_err                  (orphan),
        .rsp_err_cnt                 (ecnt)
    );

    nv_nvdla_mcif_write_eg_mc #(.NUM_CH(NUM_CH), .ID_W(ID_W), .LEN_W(LEN_W), .TIMEOUT(4)) dut_to (
        .nvdla_core_clk              (clk),
        .nvdla_core_rst              (rst),
        .noc2mcif_axi_b_bvalid       (bvalid),
        .noc2mcif_axi_b_bready       (t_bready),
        .noc2mcif_axi_b_bid          (bid),
        .noc2mcif_axi_b_bresp        (bresp),
        .cq_rd_pvld                  (pvld),
        .cq_rd_prdy                  (t_prdy),
        .cq_rd_pd                    (pd),
        .eg2ig_axi_vld               (t_eg_vld),
        .eg2ig_axi_len               (t_eg_len),
        .mcif2client_wr_rsp_complete (t_cmp),
        .mcif2client_wr_rsp_err      (t_err),
        .orphan_err                  (t_orphan),
        .rsp_err_cnt                 (t_ecnt)
    );

    typedef struct {
        int               ch;
        logic [LEN_W-1:0] len;
        logic             ack;
        logic             err;
    } exp_t;

    exp_t              sb[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    bit                mon_en = 1'b0;
    logic [NUM_CH-1:0] pend_cmp = '0;
    logic [NUM_CH-1:0] pend_err = '0;
    int                eg_cnt = 0;
    int                first_eg = 0;
    int                last_eg = 0;
    int                err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: completion/error follow the previous cycle's match; eg2ig retires the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (cmp !== pend_cmp) begin
                bad++;
                $display("FAIL mon_complete: got %b want %b at cyc %0d", cmp, pend_cmp, cyc);
            end
            total++;
            if (err !== pend_err) begin
                bad++;
                $display("FAIL mon_rsp_err: got %b want %b at cyc %0d", err, pend_err, cyc);
            end
            if (err != '0) err_pulses++;
            pend_cmp = '0;
            pend_err = '0;
            if (eg_vld === 1'b1) begin
                if (eg_cnt == 0) first_eg = cyc;
                last_eg = cyc;
                eg_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected_eg2ig: got len %0d want no pulse at cyc %0d", eg_len, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (eg_len !== e.len) begin
                        bad++;
                        $display("FAIL mon_eg2ig_len: got %0d want %0d (ch %0d)", eg_len, e.len, e.ch);
                    end
                    total++;
                    if (prdy !== (NUM_CH'(1) << e.ch)) begin
                        bad++;
                        $display("FAIL mon_cq_prdy: got %b want %b", prdy, NUM_CH'(1) << e.ch);
                    end
                    pend_cmp = e.ack ? (NUM_CH'(1) << e.ch) : '0;
                    pend_err = e.err ? (NUM_CH'(1) << e.ch) : '0;
                end
            end else begin
                total++;
                if (prdy !== '0) begin
                    bad++;
                    $display("FAIL mon_idle_prdy: got %b want 0 at cyc %0d", prdy, cyc);
                end
            end
        end
    end

    task automatic set_cq(input int ch, input int len, input bit ack);
        pd[ch*PD_W +: PD_W] = {LEN_W'(len), ack};
    endtask

    task automatic send_beat(input logic [ID_W-1:0] id, input logic [1:0] resp,
                             input bit expect_match, output int waits);
        bit acc;
        if (expect_match) begin
            exp_t             e;
            logic [PD_W-1:0]  f;
            f     = pd[int'(id)*PD_W +: PD_W];
            e.ch  = int'(id);
            e.len = f[PD_W-1:1];
            e.ack = f[0];
            e.err = (resp != 2'd0);
            sb.push_back(e);
        end
        bvalid = 1'b1;
        bid    = id;
        bresp  = resp;
        waits  = 0;
        acc    = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
        end
        bvalid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got bready 0 for 50 cycles want 1 (bid %h)", id);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending want 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bvalid   = 1'b0;
        bid      = '0;
        bresp    = 2'd0;
        mon_en   = 1'b0;
        sb.delete();
        pend_cmp = '0;
        pend_err = '0;
        pvld     = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bvalid = 1'b0;
        bid    = '0;
        bresp  = 2'd0;
        pvld   = '1;
        pd     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL reset_bready: got %b want 0", bready); end
        total++; if (eg_vld !== 1'b0) begin bad++; $display("FAIL reset_eg_vld: got %b want 0", eg_vld); end
        total++; if (eg_len !== '0) begin bad++; $display("FAIL reset_eg_len: got %0d want 0", eg_len); end
        total++; if (prdy !== '0) begin bad++; $display("FAIL reset_prdy: got %b want 0", prdy); end
        total++; if (cmp !== '0) begin bad++; $display("FAIL reset_complete: got %b want 0", cmp); end
        total++; if (err !== '0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (orphan !== 1'b0) begin bad++; $display("FAIL reset_orphan: got %b want 0", orphan); end
        total++; if (ecnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", ecnt); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bready !== 1'b1) begin bad++; $display("FAIL reset_release_bready: got %b want 1", bready); end
    endtask

    task automatic test_back_to_back();
        int lens[NUM_CH] = '{1, 2, 3, 0, 1};
        int w;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_cq(i, lens[i], 1'b1);
        eg_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            send_beat(ID_W'(i), 2'd0, 1'b1, w);
            total++;
            if (w != 0) begin bad++; $display("FAIL b2b_bready: beat %0d got %0d wait cycles want 0", i, w); end
        end
        wait_drain("b2b");
        total++; if (eg_cnt != NUM_CH) begin bad++; $display("FAIL b2b_pulse_count: got %0d want %0d", eg_cnt, NUM_CH); end
        total++; if (last_eg - first_eg != NUM_CH - 1) begin bad++; $display("FAIL b2b_consecutive: got span %0d want %0d", last_eg - first_eg, NUM_CH - 1); end
    endtask

    task automatic test_ack_err();
        int w;
        do_reset();
        set_cq(2, 2, 1'b0);
        err_pulses = 0;
        send_beat(ID_W'(2), 2'd2, 1'b1, w);
        wait_drain("ack_err");
        total++; if (ecnt !== 8'd1) begin bad++; $display("FAIL ack_err_cnt: got %0d want 1", ecnt); end
        total++; if (err_pulses != 1) begin bad++; $display("FAIL ack_err_pulses: got %0d want 1", err_pulses); end
    endtask

    task automatic test_stall();
        int w;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_cq(i, (i + 1) % 4, 1'b1);
        pvld[3] = 1'b0;
        send_beat(ID_W'(3), 2'd0, 1'b1, w);
        send_beat(ID_W'(0), 2'd1, 1'b1, w);
        begin
            exp_t e;
            e.ch = 1; e.len = LEN_W'(2); e.ack = 1'b1; e.err = 1'b0;
            sb.push_back(e);
        end
        bvalid = 1'b1;
        bid    = ID_W'(1);
        bresp  = 2'd0;
        @(negedge clk);
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL stall_full_bready: got %b want 0", bready); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL stall_held_bready: got %b want 0", bready); end
        total++; if (sb.size() != 3) begin bad++; $display("FAIL stall_no_pop: got %0d pending want 3", sb.size()); end
        @(posedge clk);
        #1;
        pvld[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bready !== 1'b1) begin bad++; $display("FAIL stall_release_bready: got %b want 1", bready); end
        @(posedge clk);
        #1;
        bvalid = 1'b0;
        wait_drain("stall");
    endtask

    task automatic test_timeout();
        int w;
        bit saw;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_cq(i, 1, 1'b1);
        pvld[1] = 1'b0;
        saw = 1'b0;
        send_beat(ID_W'(1), 2'd0, 1'b0, w);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (t_prdy != '0 || t_eg_vld) saw = 1'b1;
            if (k == 3) begin
                total++; if (t_orphan !== 1'b0) begin bad++; $display("FAIL timeout_early: got orphan %b want 0", t_orphan); end
            end
            if (k == 4) begin
                total++; if (t_orphan !== 1'b1) begin bad++; $display("FAIL timeout_orphan: got %b want 1", t_orphan); end
                total++; if (orphan !== 1'b0) begin bad++; $display("FAIL timeout_long_orphan: got %b want 0", orphan); end
            end
        end
        total++; if (saw) begin bad++; $display("FAIL timeout_no_pop: got CQ pop or eg2ig want none"); end
        total++; if (t_bready !== 1'b1) begin bad++; $display("FAIL timeout_bready: got %b want 1", t_bready); end
    endtask

    task automatic test_out_of_range();
        int w;
        int eg0;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_cq(i, 3, 1'b1);
        eg0 = eg_cnt;
        send_beat(8'h06, 2'd0, 1'b0, w);
        send_beat(8'h21, 2'd0, 1'b0, w);
        @(negedge clk);
        total++; if (orphan !== 1'b1) begin bad++; $display("FAIL oor_orphan: got %b want 1", orphan); end
        @(posedge clk);
        #1;
        total++; if (eg_cnt != eg0) begin bad++; $display("FAIL oor_no_eg2ig: got %0d pulses want 0", eg_cnt - eg0); end
        send_beat(ID_W'(0), 2'd0, 1'b1, w);
        wait_drain("oor_follow");
    endtask

    task automatic test_mid_reset();
        int w;
        int eg0;
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_cq(i, 3, 1'b1);
        pvld = 5'b10000;
        send_beat(ID_W'(4), 2'd3, 1'b1, w);
        wait_drain("mid_pre");
        total++; if (ecnt !== 8'd1) begin bad++; $display("FAIL mid_err_cnt_pre: got %0d want 1", ecnt); end
        send_beat(ID_W'(0), 2'd0, 1'b0, w);
        send_beat(ID_W'(1), 2'd0, 1'b0, w);
        rst    = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        total++; if (eg_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_eg_vld: got %b want 0", eg_vld); end
        total++; if (prdy !== '0) begin bad++; $display("FAIL mid_rst_prdy: got %b want 0", prdy); end
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL mid_rst_bready: got %b want 0", bready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL mid_post_bready: got %b want 0", bready); end
        total++; if (eg_vld !== 1'b0) begin bad++; $display("FAIL mid_post_eg_vld: got %b want 0", eg_vld); end
        total++; if (cmp !== '0) begin bad++; $display("FAIL mid_post_complete: got %b want 0", cmp); end
        total++; if (ecnt !== 8'd0) begin bad++; $display("FAIL mid_post_err_cnt: got %0d want 0", ecnt); end
        total++; if (orphan !== 1'b0) begin bad++; $display("FAIL mid_post_orphan: got %b want 0", orphan); end
        pvld     = '1;
        sb.delete();
        pend_cmp = '0;
        pend_err = '0;
        eg0      = eg_cnt;
        mon_en   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (bready !== 1'b1) begin bad++; $display("FAIL mid_empty_bready: got %b want 1", bready); end
        total++; if (eg_cnt != eg0) begin bad++; $display("FAIL mid_stale_eg2ig: got %0d pulses want 0", eg_cnt - eg0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_ack_err();
        test_stall();
        test_timeout();
        test_out_of_range();
        test_mid_reset();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_mcif_write_eg_mc.md
Name: nv_nvdla_mcif_write_eg_mc

Overview:
- Parametrised write-response egress for MCIF.
- Accepts AXI B-channel beats from the NoC and matches each one, by ID, to the head of that channel's completion queue (CQ). It then returns the burst length to ingress for credit release and pulses per-channel write-complete.
- Beyond the previous generation, it adds:
  - a channel count set by parameter;
  - BRESP error reporting;
  - orphan and out-of-range ID detection;
  - a stall timeout that drops stuck responses.

Parameters:
- NUM_CH, 5, number of write DMA channels (1..8).
- ID_W, 8, width of noc2mcif_axi_b_bid.
- LEN_W, 2, burst-length field width in the CQ payload and on eg2ig_axi_len.
- TIMEOUT, 255, head-stall cycles before an unmatched response is dropped (1..65535).
- CH_W, derived as max(1, clog2(NUM_CH)), width of the channel select taken from bid.

Ports:
- nvdla_core_clk, input, 1, core clock.
- nvdla_core_rst, input, 1, synchronous active-high reset.
- noc2mcif_axi_b_bvalid, input, 1, B beat valid.
- noc2mcif_axi_b_bready, output, 1, B beat ready.
- noc2mcif_axi_b_bid, input, ID_W, B beat ID.
- noc2mcif_axi_b_bresp, input, 2, B beat response code.
- cq_rd_pvld, input, NUM_CH, per-channel CQ head valid.
- cq_rd_prdy, output, NUM_CH, per-channel CQ pop.
- cq_rd_pd, input, NUM_CH*(LEN_W+1), per-channel CQ head payload. Channel i occupies bits [i*(LEN_W+1) +: LEN_W+1]; bit 0 is require_ack, bits [LEN_W:1] are len.
- eg2ig_axi_vld, output, 1, credit return valid (single-cycle pulse, no backpressure).
- eg2ig_axi_len, output, LEN_W, credit return length.
- mcif2client_wr_rsp_complete, output, NUM_CH, registered per-channel completion pulse.
- mcif2client_wr_rsp_err, output, NUM_CH, registered per-channel pulse when BRESP is not zero.
- orphan_err, output, 1, sticky flag: a response was dropped.
- rsp_err_cnt, output, 8, saturating count of BRESP errors.

Behaviour:
- Reset (synchronous, nvdla_core_rst=1 at a clock edge) sets the following to 0: all outputs, the skid contents, the stall counter, orphan_err and rsp_err_cnt.
  - noc2mcif_axi_b_bready is 0 while reset is high.
  - Reset mid-operation discards skid contents; the CQs are not popped.
- Input stage: 2-entry skid buffer storing {bid[CH_W-1:0], bid_hi_nonzero, bresp}.
  - bready = !reset and skid count < 2. bready is driven from registers only.
  - A beat is accepted when bvalid and bready are both high.
  - Simultaneous push and pop while count is 2 is not possible, because bready is 0 when count is 2.
- Match stage: operates on the skid head when the head is valid. c is the head's channel field.
  - Out-of-range: bid_hi_nonzero set, or c >= NUM_CH.
    - Pop the head and set orphan_err.
    - No cq_rd_prdy, no eg2ig pulse, no completion.
  - Match: in range and cq_rd_pvld[c]=1, all in the same cycle:
    - cq_rd_prdy[c]=1 (combinational, single-hot);
    - pop the head;
    - eg2ig_axi_vld=1, with eg2ig_axi_len equal to len[c].
  - Stall: in range and cq_rd_pvld[c]=0.
    - Hold the head and increment the stall counter.
    - When the counter reaches TIMEOUT: pop the head without a CQ pop, set orphan_err, clear the counter.
    - The counter also clears on every pop.
  - No head valid: eg2ig_axi_vld=0, all cq_rd_prdy=0, and eg2ig_axi_len=0 (never X).
- Completion, registered one cycle after a match:
  - mcif2client_wr_rsp_complete[c] = require_ack[c].
  - mcif2client_wr_rsp_err[c] = (bresp != 0). This pulses regardless of require_ack.
  - rsp_err_cnt increments on each err pulse and saturates at 255.
- Latency and throughput:
  - A beat accepted at edge T is at the head at T+1, giving eg2ig/cq pop in cycle T+1 and the complete pulse at T+2.
  - Sustained throughput is 1 response per cycle when CQs are ready.
- Ordering: strictly in-order. A stalled head blocks all channels (head-of-line blocking by design).
- cq_rd_pvld for channels other than c is ignored.
- orphan_err clears only on reset.

Decomposition:
- Shared package nv_nvdla_mcif_wr_pkg holds:
  - CQ payload field offsets (ACK_BIT=0, LEN_LSB=1);
  - AXI resp codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - a clog2 function.
- One sub-module: nv_nvdla_mcif_write_eg_skid, a 2-entry valid/ready skid buffer with width parameter, registered ready and synchronous reset.

Test Plan:
- Back-to-back matches: NUM_CH=5; bids 0,1,2,3,4 on consecutive cycles; all CQs valid with len=1,2,3,0,1 and ack=1.
  - eg2ig pulses on 5 consecutive cycles with those lens.
  - complete[i] pulses one cycle after each eg2ig pulse.
  - bready stays 1 throughout.
- Ack suppression and error: bid=2, bresp=2, ack=0.
  - cq_rd_prdy[2] pulses.
  - complete[2] stays 0.
  - wr_rsp_err[2] pulses once.
  - rsp_err_cnt goes to 1.
- Stall and backpressure: bid=3 with cq_rd_pvld[3]=0, then two further beats.
  - Skid fills and bready=0 after the second queued beat.
  - Raise cq_rd_pvld[3] after 10 cycles: head pops and bready returns to 1 on the next cycle.
- Timeout: TIMEOUT=4, bid=1, cq_rd_pvld[1] held 0.
  - Head dropped after 4 stall cycles.
  - orphan_err=1, cq_rd_prdy[1] never asserted, no eg2ig pulse.
- Out-of-range ID: bid=8'h06 and then bid=8'h21 with NUM_CH=5.
  - Both dropped one cycle after acceptance.
  - orphan_err=1, no CQ pops.
- Mid-operation reset: two beats in the skid, then reset asserted for 1 cycle.
  - All outputs 0 and bready=0 during reset.
  - After reset, count=0 and no stale eg2ig pulse; rsp_err_cnt=0.
